// File: rtl/saturn_bus_sequencer.sv
// Saturn nibble-bus sequencer: queues command/data nibbles from the control unit,
// drives them on the 4-phase bus cycle, and performs idle reads with a one-clock strobe.
//
// mode   | meaning
// IDLE   | no bus transfer in this 4-phase cycle
// WRITE  | a queued entry was driven at P0
// READ   | idle read started at P0, nibble captured at P1
module saturn_bus_sequencer #(
    parameter int PROG_DEPTH_LOG2 = 5,
    parameter int NIBBLE_W        = 4
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_clk_en,
    input  logic                       i_stall,
    input  logic [3:0]                 i_phases,
    input  logic                       i_prog_valid,
    input  logic [NIBBLE_W:0]          i_prog_data,
    output logic                       o_prog_ready,
    input  logic                       i_no_read,
    output logic                       o_bus_clk_en,
    output logic                       o_bus_is_data,
    output logic [NIBBLE_W-1:0]        o_bus_nibble_out,
    input  logic [NIBBLE_W-1:0]        i_bus_nibble_in,
    output logic [NIBBLE_W-1:0]        o_read_nibble,
    output logic                       o_read_valid,
    output logic                       o_busy,
    output logic [PROG_DEPTH_LOG2:0]   o_fifo_level,
    output logic                       o_error
);

    localparam int DEPTH = 2 ** PROG_DEPTH_LOG2;
    localparam logic [PROG_DEPTH_LOG2:0] FULL_LEVEL = (PROG_DEPTH_LOG2 + 1)'(DEPTH);

    localparam logic [1:0] MODE_IDLE  = 2'd0;
    localparam logic [1:0] MODE_WRITE = 2'd1;
    localparam logic [1:0] MODE_READ  = 2'd2;

    logic [NIBBLE_W:0]          fifo_mem [DEPTH];
    logic [PROG_DEPTH_LOG2-1:0] wr_ptr;
    logic [PROG_DEPTH_LOG2-1:0] rd_ptr;
    logic [1:0]                 mode;
    logic [NIBBLE_W:0]          head;

    logic en;
    logic phase_ok;
    logic p0, p1, p2, p3;
    logic push, pop;
    logic fifo_empty;

    assign en       = i_clk_en && !i_stall;
    assign phase_ok = (i_phases == 4'b0001) || (i_phases == 4'b0010) ||
                      (i_phases == 4'b0100) || (i_phases == 4'b1000);
    assign p0 = en && (i_phases == 4'b0001);
    assign p1 = en && (i_phases == 4'b0010);
    assign p2 = en && (i_phases == 4'b0100);
    assign p3 = en && (i_phases == 4'b1000);

    assign o_prog_ready = (o_fifo_level != FULL_LEVEL);
    assign fifo_empty   = (o_fifo_level == '0);
    assign push         = i_prog_valid && o_prog_ready;
    // pop looks at the pre-edge level, so a push on the same P0 into an empty queue waits a cycle
    assign pop          = p0 && !fifo_empty;
    assign head         = fifo_mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= i_prog_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            o_fifo_level     <= '0;
            mode             <= MODE_IDLE;
            o_bus_clk_en     <= 1'b0;
            o_bus_is_data    <= 1'b0;
            o_bus_nibble_out <= '0;
            o_read_nibble    <= '0;
            o_read_valid     <= 1'b0;
            o_busy           <= 1'b1;
            o_error          <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   o_fifo_level <= o_fifo_level + 1'b1;
                2'b01:   o_fifo_level <= o_fifo_level - 1'b1;
                default: o_fifo_level <= o_fifo_level;
            endcase

            o_read_valid <= 1'b0;

            if (en && !phase_ok) begin
                o_error <= 1'b1;
            end

            if (p0) begin
                if (!fifo_empty) begin
                    o_bus_nibble_out <= head[NIBBLE_W-1:0];
                    o_bus_is_data    <= !head[NIBBLE_W];
                    o_bus_clk_en     <= 1'b1;
                    o_busy           <= 1'b1;
                    mode             <= MODE_WRITE;
                end else if (!i_no_read) begin
                    o_bus_is_data <= 1'b1;
                    o_bus_clk_en  <= 1'b1;
                    mode          <= MODE_READ;
                end else begin
                    mode <= MODE_IDLE;
                end
            end

            if (p1) begin
                o_bus_clk_en <= 1'b0;
                if (mode == MODE_READ) begin
                    o_read_nibble <= i_bus_nibble_in;
                end
            end

            if (p2) begin
                // reads issued while a program was still in flight are not reported
                if ((mode == MODE_READ) && !o_busy) begin
                    o_read_valid <= 1'b1;
                end
                if (fifo_empty && !push && o_busy) begin
                    o_busy <= 1'b0;
                end
            end

            if (p3) begin
                mode <= MODE_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_saturn_bus_sequencer.sv
// Self-checking bench for saturn_bus_sequencer: directed vector table, corner-case
// sequences, and randomized traffic against a queue-based reference model.
module tb_saturn_bus_sequencer;

    localparam int LOG2  = 5;
    localparam int NW    = 4;
    localparam int DEPTH = 32;

    localparam int M_IDLE  = 0;
    localparam int M_WRITE = 1;
    localparam int M_READ  = 2;

    logic            i_clk = 1'b0;
    logic            i_reset = 1'b1;
    logic            i_clk_en = 1'b1;
    logic            i_stall = 1'b0;
    logic [3:0]      i_phases = 4'b1000;
    logic            i_prog_valid = 1'b0;
    logic [NW:0]     i_prog_data = '0;
    logic            i_no_read = 1'b0;
    logic [NW-1:0]   i_bus_nibble_in = '0;
    logic            o_prog_ready;
    logic            o_bus_clk_en;
    logic            o_bus_is_data;
    logic [NW-1:0]   o_bus_nibble_out;
    logic [NW-1:0]   o_read_nibble;
    logic            o_read_valid;
    logic            o_busy;
    logic [LOG2:0]   o_fifo_level;
    logic            o_error;

    saturn_bus_sequencer #(.PROG_DEPTH_LOG2(LOG2), .NIBBLE_W(NW)) dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .i_clk_en         (i_clk_en),
        .i_stall          (i_stall),
        .i_phases         (i_phases),
        .i_prog_valid     (i_prog_valid),
        .i_prog_data      (i_prog_data),
        .o_prog_ready     (o_prog_ready),
        .i_no_read        (i_no_read),
        .o_bus_clk_en     (o_bus_clk_en),
        .o_bus_is_data    (o_bus_is_data),
        .o_bus_nibble_out (o_bus_nibble_out),
        .i_bus_nibble_in  (i_bus_nibble_in),
        .o_read_nibble    (o_read_nibble),
        .o_read_valid     (o_read_valid),
        .o_busy           (o_busy),
        .o_fifo_level     (o_fifo_level),
        .o_error          (o_error)
    );

    always #5 i_clk = ~i_clk;

    int errors = 0;
    int checks = 0;

    // reference model: the queue holds pending entries, scalars hold bus/status outputs
    logic [NW:0]   mq [$];
    logic          m_clk_en = 1'b0, m_is_data = 1'b0, m_rvalid = 1'b0, m_busy = 1'b1, m_err = 1'b0;
    logic [NW-1:0] m_nib = '0, m_rnib = '0;
    int            m_mode = M_IDLE;

    typedef struct {
        logic [3:0]    phases;
        logic [NW-1:0] bus_in;
        logic          exp_clk_en;
        logic          exp_is_data;
        logic          exp_busy;
        logic          exp_rvalid;
        logic [NW-1:0] exp_rnib;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_edge();
        logic        push;
        logic        en;
        int          pre;
        logic [NW:0] e;
        if (i_reset) begin
            mq.delete();
            m_clk_en = 1'b0; m_is_data = 1'b0; m_nib = '0; m_rnib = '0;
            m_rvalid = 1'b0; m_busy = 1'b1; m_err = 1'b0; m_mode = M_IDLE;
            return;
        end
        pre  = mq.size();
        push = i_prog_valid && (pre < DEPTH);
        en   = i_clk_en && !i_stall;
        m_rvalid = 1'b0;
        if (en) begin
            if ($countones(i_phases) != 1) begin
                m_err = 1'b1;
            end else if (i_phases[0]) begin
                if (pre > 0) begin
                    e = mq.pop_front();
                    m_nib = e[NW-1:0]; m_is_data = !e[NW]; m_clk_en = 1'b1;
                    m_busy = 1'b1; m_mode = M_WRITE;
                end else if (!i_no_read) begin
                    m_is_data = 1'b1; m_clk_en = 1'b1; m_mode = M_READ;
                end else begin
                    m_mode = M_IDLE;
                end
            end else if (i_phases[1]) begin
                m_clk_en = 1'b0;
                if (m_mode == M_READ) m_rnib = i_bus_nibble_in;
            end else if (i_phases[2]) begin
                if (m_mode == M_READ && !m_busy) m_rvalid = 1'b1;
                if (pre + int'(push) == 0) m_busy = 1'b0;
            end else begin
                m_mode = M_IDLE;
            end
        end
        if (push) mq.push_back(i_prog_data);
    endtask

    task automatic tick();
        @(posedge i_clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1; i_prog_valid = 1'b0; i_clk_en = 1'b1; i_stall = 1'b0;
        i_phases = 4'b1000; i_no_read = 1'b0;
        tick();
        tick();
        i_reset = 1'b0;
    endtask

    task automatic push_entry(input logic [NW:0] d);
        i_clk_en = 1'b0; i_prog_valid = 1'b1; i_prog_data = d;
        tick();
        i_prog_valid = 1'b0;
    endtask

    task automatic phase(input int p);
        i_clk_en = 1'b1;
        i_phases = 4'b0001 << p;
        tick();
    endtask

    initial begin
        logic [19:0] act_v, exp_v;
        logic [NW:0] e;
        int ph;

        vecs[0] = '{4'b0001, 4'hA, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0};
        vecs[1] = '{4'b0010, 4'hA, 1'b0, 1'b1, 1'b1, 1'b0, 4'hA};
        vecs[2] = '{4'b0100, 4'hA, 1'b0, 1'b1, 1'b0, 1'b0, 4'hA};
        vecs[3] = '{4'b1000, 4'hA, 1'b0, 1'b1, 1'b0, 1'b0, 4'hA};
        vecs[4] = '{4'b0001, 4'hA, 1'b1, 1'b1, 1'b0, 1'b0, 4'hA};
        vecs[5] = '{4'b0010, 4'hC, 1'b0, 1'b1, 1'b0, 1'b0, 4'hC};
        vecs[6] = '{4'b0100, 4'hC, 1'b0, 1'b1, 1'b0, 1'b1, 4'hC};
        vecs[7] = '{4'b1000, 4'hC, 1'b0, 1'b1, 1'b0, 1'b0, 4'hC};

        // reset state, then post-reset idle reads
        i_bus_nibble_in = 4'hA;
        do_reset();
        check("rst_clk_en", 32'(o_bus_clk_en), 32'd0);
        check("rst_is_data", 32'(o_bus_is_data), 32'd0);
        check("rst_nibble", 32'(o_bus_nibble_out), 32'd0);
        check("rst_rnib", 32'(o_read_nibble), 32'd0);
        check("rst_rvalid", 32'(o_read_valid), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd1);
        check("rst_level", 32'(o_fifo_level), 32'd0);
        check("rst_ready", 32'(o_prog_ready), 32'd1);
        check("rst_error", 32'(o_error), 32'd0);
        for (int i = 0; i < 8; i++) begin
            i_phases = vecs[i].phases;
            i_bus_nibble_in = vecs[i].bus_in;
            tick();
            check($sformatf("tbl%0d_clk_en", i), 32'(o_bus_clk_en), 32'(vecs[i].exp_clk_en));
            check($sformatf("tbl%0d_is_data", i), 32'(o_bus_is_data), 32'(vecs[i].exp_is_data));
            check($sformatf("tbl%0d_busy", i), 32'(o_busy), 32'(vecs[i].exp_busy));
            check($sformatf("tbl%0d_rvalid", i), 32'(o_read_valid), 32'(vecs[i].exp_rvalid));
            check($sformatf("tbl%0d_rnib", i), 32'(o_read_nibble), 32'(vecs[i].exp_rnib));
        end

        // command then data entry, no read strobe
        do_reset();
        push_entry(5'h13);
        push_entry(5'h05);
        for (int c = 0; c < 2; c++) begin
            for (int p = 0; p < 4; p++) begin
                phase(p);
                check("cd_rvalid", 32'(o_read_valid), 32'd0);
                if (p == 0) begin
                    check("cd_nibble", 32'(o_bus_nibble_out), (c == 0) ? 32'd3 : 32'd5);
                    check("cd_is_data", 32'(o_bus_is_data), (c == 0) ? 32'd0 : 32'd1);
                    check("cd_clk_en", 32'(o_bus_clk_en), 32'd1);
                end
                if (p == 2) check("cd_busy", 32'(o_busy), (c == 0) ? 32'd1 : 32'd0);
            end
        end

        // fill to full, hold the 33rd, order across pointer wrap
        do_reset();
        i_no_read = 1'b1;
        for (int i = 0; i < DEPTH; i++) push_entry(5'(i));
        check("full_level", 32'(o_fifo_level), 32'd32);
        check("full_ready", 32'(o_prog_ready), 32'd0);
        i_clk_en = 1'b0; i_prog_valid = 1'b1; i_prog_data = 5'h0B;
        tick();
        check("held_level", 32'(o_fifo_level), 32'd32);
        phase(0);
        check("pop_level", 32'(o_fifo_level), 32'd31);
        check("pop_ready", 32'(o_prog_ready), 32'd1);
        check("pop_first", 32'(o_bus_nibble_out), 32'd0);
        phase(1);
        i_prog_valid = 1'b0;
        check("accept_level", 32'(o_fifo_level), 32'd32);
        phase(2);
        phase(3);
        for (int k = 1; k <= DEPTH; k++) begin
            e = (k == DEPTH) ? 5'h0B : 5'(k);
            phase(0);
            check($sformatf("order%0d_nib", k), 32'(o_bus_nibble_out), 32'(e[NW-1:0]));
            check($sformatf("order%0d_is_data", k), 32'(o_bus_is_data), 32'(!e[NW]));
            phase(1); phase(2); phase(3);
        end
        check("drain_level", 32'(o_fifo_level), 32'd0);

        // stall during P0
        do_reset();
        push_entry(5'h12);
        push_entry(5'h04);
        i_clk_en = 1'b1; i_stall = 1'b1; i_phases = 4'b0001;
        tick();
        check("stall_clk_en", 32'(o_bus_clk_en), 32'd0);
        check("stall_level", 32'(o_fifo_level), 32'd2);
        i_stall = 1'b0;
        phase(1); phase(2); phase(3); phase(0);
        check("unstall_clk_en", 32'(o_bus_clk_en), 32'd1);
        check("unstall_level", 32'(o_fifo_level), 32'd1);
        check("unstall_nib", 32'(o_bus_nibble_out), 32'd2);
        check("unstall_is_data", 32'(o_bus_is_data), 32'd0);

        // invalid phase sets sticky error
        do_reset();
        push_entry(5'h01);
        i_clk_en = 1'b1; i_phases = 4'b0011;
        tick();
        check("err_set", 32'(o_error), 32'd1);
        check("err_no_pop", 32'(o_fifo_level), 32'd1);
        phase(0); phase(1); phase(2);
        check("err_sticky", 32'(o_error), 32'd1);
        push_entry(5'h02);
        do_reset();
        check("err_rst_error", 32'(o_error), 32'd0);
        check("err_rst_level", 32'(o_fifo_level), 32'd0);
        check("err_rst_busy", 32'(o_busy), 32'd1);

        // push and pop on the same P0 edge with one entry queued
        do_reset();
        i_no_read = 1'b1;
        push_entry(5'h17);
        i_clk_en = 1'b1; i_prog_valid = 1'b1; i_prog_data = 5'h09; i_phases = 4'b0001;
        tick();
        i_prog_valid = 1'b0;
        check("pp_level", 32'(o_fifo_level), 32'd1);
        check("pp_nib", 32'(o_bus_nibble_out), 32'd7);
        check("pp_is_data", 32'(o_bus_is_data), 32'd0);
        phase(1); phase(2); phase(3); phase(0);
        check("pp_next_nib", 32'(o_bus_nibble_out), 32'd9);
        check("pp_next_is_data", 32'(o_bus_is_data), 32'd1);
        check("pp_next_level", 32'(o_fifo_level), 32'd0);

        // randomized traffic against the reference model
        do_reset();
        ph = 3;
        for (int n = 0; n < 4000; n++) begin
            i_reset  = ($urandom_range(0, 499) == 0);
            i_clk_en = ($urandom_range(0, 9) != 0);
            i_stall  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 299) == 0) begin
                i_phases = 4'($urandom);
            end else begin
                ph = (ph + 1) % 4;
                i_phases = 4'b0001 << ph;
            end
            i_prog_valid = (n < 2000) ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 7) == 0);
            i_prog_data = 5'($urandom);
            i_no_read = ($urandom_range(0, 3) == 0);
            i_bus_nibble_in = 4'($urandom);
            tick();
            act_v = {o_bus_clk_en, o_bus_is_data, o_bus_nibble_out, o_read_nibble, o_read_valid,
                     o_busy, o_fifo_level, o_prog_ready, o_error};
            exp_v = {m_clk_en, m_is_data, m_nib, m_rnib, m_rvalid,
                     m_busy, 6'(mq.size()), (mq.size() < DEPTH), m_err};
            check($sformatf("rand%0d", n), 32'(act_v), 32'(exp_v));
        end
        i_reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/saturn_bus_sequencer.md
# saturn_bus_sequencer

Parametrised bus sequencer for the Saturn core. It sits between the control unit and the external nibble bus. Bus words (command or data nibbles) are queued through a valid/ready FIFO port, replacing shared-pointer program lists. The sequencer drives them onto the bus on the 4-phase cycle, performs reads when idle, and returns read nibbles with a one-clock valid strobe. It also reports busy/level/error status for halting and for the debugger.

## Interface
- `PROG_DEPTH_LOG2`, default 5: FIFO depth is 2**PROG_DEPTH_LOG2 entries.
- `NIBBLE_W`, default 4: bus data width.
- `i_clk`  in  1  clock.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_clk_en`  in  1  global clock enable.
- `i_stall`  in  1  debugger stall. Phase work runs only when `en = i_clk_en && !i_stall`.
- `i_phases`  in  4  one-hot phase (bit0..bit3 = P0..P3).
- `i_prog_valid`  in  1  control unit offers a program entry.
- `i_prog_data`  in  NIBBLE_W+1  entry: bit[NIBBLE_W] = 1 for command, 0 for data; low bits are the nibble.
- `o_prog_ready`  out  1  FIFO not full (combinational).
- `i_no_read`  in  1  suppress idle reads.
- `o_bus_clk_en`  out  1  bus strobe.
- `o_bus_is_data`  out  1  1 = data cycle, 0 = command cycle.
- `o_bus_nibble_out`  out  NIBBLE_W  nibble driven to the bus.
- `i_bus_nibble_in`  in  NIBBLE_W  nibble from the bus.
- `o_read_nibble`  out  NIBBLE_W  last captured read nibble.
- `o_read_valid`  out  1  one-clock strobe: `o_read_nibble` is new.
- `o_busy`  out  1  program transmission in progress.
- `o_fifo_level`  out  PROG_DEPTH_LOG2+1  number of queued entries.
- `o_error`  out  1  sticky; set on a non-one-hot phase while `en` is high.

## Operation
- **FIFO**
  - Circular buffer with read and write pointers that wrap modulo depth.
  - Push occurs when `i_prog_valid && o_prog_ready`. Push is not gated by `en`.
  - Pop occurs only in P0 with `en` high and level > 0.
  - Push and pop on the same clock: both take effect and the level is unchanged.
  - Valid while full is not an error; the entry is held by the producer until ready.
- **Internal mode register**: IDLE, WRITE or READ.
- **P0 (en)**
  - Level > 0: pop the entry. Set `o_bus_nibble_out` = entry[NIBBLE_W-1:0], `o_bus_is_data` = !entry[NIBBLE_W], `o_bus_clk_en` = 1, `o_busy` = 1, mode = WRITE.
  - Level = 0 and `!i_no_read`: set `o_bus_is_data` = 1, `o_bus_clk_en` = 1, mode = READ. `o_bus_nibble_out` holds its value.
  - Level = 0 and `i_no_read`: mode = IDLE; outputs unchanged.
- **P1 (en)**: `o_bus_clk_en` <= 0. If mode = READ, `o_read_nibble` <= `i_bus_nibble_in`.
- **P2 (en)**
  - If mode = READ and `o_busy` = 0 (pre-edge value): `o_read_valid` <= 1.
  - If FIFO is empty after this clock's push and `o_busy` = 1: `o_busy` <= 0.
- **P3 (en)**: mode <= IDLE.
- **Invalid phase**: `i_phases` not one-hot with `en` high sets `o_error` and takes no other phase action.
- **`en` low**: FIFO push still works; phase state, bus outputs and mode are held. `o_read_valid` still clears.

## Timing
- **Reset values**
  - `o_bus_clk_en`, `o_bus_is_data`, `o_bus_nibble_out`, `o_read_nibble`, `o_read_valid`, `o_fifo_level`, `o_error` = 0.
  - `o_busy` = 1.
  - Pointers = 0, mode = IDLE.
  - `o_prog_ready` = 1 after reset.
- Reset has priority over push, pop and phase actions on the same edge. Reset mid-cycle discards queued entries and any pending read.
- `o_read_valid` is high for exactly one `i_clk` after the P2 edge, then clears on the next edge, whether or not `en` is high.
- **Latency**
  - An entry pushed before a P0 edge is driven at that edge.
  - An entry pushed on the same edge as P0 into an empty FIFO waits for the next P0.
- One entry per 4-phase cycle; a queue of N entries takes N bus cycles.
- `o_busy` falls at the first P2 at which the FIFO is empty. Reads started while busy are performed but not strobed.
- `o_fifo_level` updates on the edge after push/pop; `o_prog_ready` = (level != 2**PROG_DEPTH_LOG2).

## Test plan
- **Post-reset read, no pushes, `i_no_read` = 0, bus = 4'hA**:
  - Required: first P0 gives `o_bus_clk_en` = 1, `is_data` = 1.
  - First P2 clears `o_busy`.
  - Second cycle's P2 gives `o_read_valid` for one clock with `o_read_nibble` = 4'hA.
- **Push {1,4'h3},{0,4'h5}**:
  - Required: successive P0s drive cmd 3 (`is_data` = 0), then data 5 (`is_data` = 1).
  - `o_busy` clears at the P2 after the second entry.
  - No `o_read_valid` strobe.
- **Fill 32 entries (default params)**:
  - Required: `o_prog_ready` = 0 and level = 32.
  - A 33rd valid is held.
  - After the next P0 pop: ready = 1 and the held entry is accepted.
  - Order is preserved across pointer wrap.
- **`i_stall` = 1 during P0 with 2 entries queued**:
  - Required: no pop and `o_bus_clk_en` stays 0.
  - After stall release, the next P0 pops normally.
- **`i_phases` = 4'b0011 with `en` high**:
  - Required: `o_error` = 1 and stays 1 until reset.
  - Reset clears it, and sets level = 0 and `o_busy` = 1.
- **Push and pop on the same P0 edge with level = 1**:
  - Required: level stays 1.
  - The popped nibble is the older entry.
